// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter, launching one byte per transmit.
// Latency: a byte pushed into an empty, idle FIFO launches on the following clk edge.
// Backpressure: pushes to a full FIFO are dropped and flagged in sticky 'overflow'.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   wr_en, wr_data        - push request and byte
//   flush, clr_ovf        - synchronous FIFO clear, overflow flag clear
//   full, empty, count    - registered occupancy status
//   overflow              - sticky flag, set when a push is dropped
//   tx_start, tx_data     - one-cycle launch pulse and the launched byte (held)
//   tx_busy, tx_done      - transmitter busy level and completion pulse
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          clr_ovf,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  input  logic          tx_done
);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t      state;
  logic [7:0]  mem [DEPTH];
  // Pointers carry one extra bit so that wptr - rptr distinguishes full from empty.
  logic [AW:0] wptr, rptr;
  logic [AW:0] wptr_nxt, rptr_nxt, count_nxt;
  logic        push, drop, launch;

  // Flush swallows any push on its edge and blocks a launch on that edge.
  assign push   = wr_en && !full && !flush;
  assign drop   = wr_en &&  full && !flush;
  assign launch = (state == IDLE) && !empty && !tx_busy && !flush;

  always_comb begin
    wptr_nxt  = wptr + (AW+1)'(push);
    rptr_nxt  = rptr + (AW+1)'(launch);
    if (flush) begin
      wptr_nxt = '0;
      rptr_nxt = '0;
    end
    count_nxt = wptr_nxt - rptr_nxt;
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push && !reset)
      mem[wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);

      // A new drop wins over a clear on the same edge.
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;

      tx_start <= launch;
      if (launch)
        tx_data <= mem[rptr[AW-1:0]];

      // Flush leaves the FSM alone so an in-flight byte runs to completion.
      case (state)
        IDLE:      if (launch)  state <= WAIT_BUSY;
        WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
        WAIT_DONE: if (tx_done) state <= IDLE;
        default:                state <= IDLE;
      endcase
    end
  end

endmodule
